maindec_fsm: RTL and testbench
==============================

# maindec_fsm

Multicycle main controller for the MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and muxes. Its `aluop` output feeds the ALU decoder directly, and `funct` passes through to that decoder. It adds a memory-ready handshake so instruction and data accesses can take more than one cycle.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  6  opcode field of the instruction register
- `memready`  in  1  memory has completed the current access this cycle
- `pcwrite`  out  1  unconditional PC load
- `branch`  out  1  conditional PC load; the datapath ANDs it with zero
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  data memory write request
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  write register select: 0 = rt, 1 = rd
- `memtoreg`  out  1  writeback select: 0 = ALUOut, 1 = Data
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `aluop`  out  2  00 = add, 01 = sub, 10 = use funct
- `illegal`  out  1  one-cycle flag: unrecognised opcode seen in DECODE

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Every output not listed for a state is 0.
  - FETCH: alusrcb=01; irwrite=memready; pcwrite=memready.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1 (held for the whole stall).
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH→DECODE when memready=1, else stay in FETCH.
  - DECODE on `op`: 100011/101011→MEMADR; 000000→RTYPEEX; 000100→BEQEX; 001000→ADDIEX; 000010→JEX (macro-gated); any other opcode→FETCH with `illegal`=1.
  - MEMADR→MEMRD if op=100011, else→MEMWR.
  - MEMRD→MEMWB when memready=1, else stay.
  - MEMWR→FETCH when memready=1, else stay.
  - RTYPEEX→RTYPEWB; ADDIEX→ADDIWB.
  - MEMWB, RTYPEWB, BEQEX, ADDIWB and JEX all go →FETCH.
- `op` is sampled only in DECODE and MEMADR. The IR is stable from the end of FETCH onward.

## Timing
- State register updates on the rising edge of `clk`. All outputs decode combinationally from the state plus `memready`. There are no registered outputs.
- While `reset_n`=0: state is forced to FETCH and every output is forced to 0, including irwrite and pcwrite even if memready=1. On release, the first edge behaves as FETCH.
- Reset asserted mid-instruction aborts immediately. An in-flight MEMWR deasserts memwrite asynchronously.
- Instruction cycles with memready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
  - Each cycle memready is low adds one cycle in FETCH, MEMRD or MEMWR.
- `illegal` is asserted only in the DECODE cycle that detects the bad opcode. The instruction costs 2 cycles in total.

## Configuration
- `MAINDEC_JUMP_EN` defined: the JEX state exists and op 000010 performs a jump.
- `MAINDEC_JUMP_EN` undefined: JEX is not compiled. Op 000010 is treated as illegal (DECODE→FETCH, `illegal`=1), and pcsrc never takes the value 10.

## Structure
- Package `mips_pkg` holds:
  - the `statetype` enum (4-bit, FETCH=0 … JEX=11);
  - opcode localparams OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - aluop constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
- One sub-module, `maindec_outdec`: a combinational map from (`statetype`, `memready`) to the 15-bit control word. The top-level module holds the state register, the next-state logic and the reset gating.

## Test plan
- Reset held low with memready=1 → all outputs 0. After release, the first cycle shows irwrite=1, pcwrite=1, alusrcb=01.
- lw (op=100011), memready=1 → FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. memtoreg=1 and regwrite=1 only in cycle 5.
- sw (op=101011) with memready low for 3 cycles in MEMWR → memwrite=1 and iord=1 for 4 consecutive cycles, then FETCH.
- R-type (op=000000) → aluop=10 in cycle 3; regdst=1 and regwrite=1 in cycle 4. beq → aluop=01 and branch=1 in cycle 3.
- op=111111 → `illegal`=1 for exactly one cycle in DECODE, then FETCH. Repeat with op=000010: jump in cycle 3 when `MAINDEC_JUMP_EN` is defined, `illegal` pulse when it is not.
- reset_n pulsed low during MEMWR stall → memwrite drops to 0 immediately; the machine resumes in FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// Optional feature macro: MAINDEC_JUMP_EN (adds the JEX jump state).
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/maindec_outdec.sv
// Moore output decode: (state, memready) -> 15-bit control word.
// Optional feature macro: MAINDEC_JUMP_EN (decodes the JEX state).
module maindec_outdec
  import mips_pkg::*;
(
  input  statetype state,
  input  logic     memready,
  output ctrl_t    ctrl
);

  // Per-state control word; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = memready;
        ctrl.pcwrite = memready;
      end
      DECODE: ctrl.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
`ifdef MAINDEC_JUMP_EN
      JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/maindec_fsm.sv
// Multicycle MIPS main controller with memory-ready stalls.
// Optional feature macro: MAINDEC_JUMP_EN (j instruction support).
module maindec_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  statetype state, next;
  logic     bad_op;
  ctrl_t    ctrl, ctrl_g;

  // State register; reset aborts any instruction back to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next;
  end

  // Next-state logic and illegal-opcode detection in DECODE.
  always_comb begin
    next   = state;
    bad_op = 1'b0;
    case (state)
      FETCH:   if (memready) next = DECODE;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = RTYPEEX;
          OP_BEQ:       next = BEQEX;
          OP_ADDI:      next = ADDIEX;
`ifdef MAINDEC_JUMP_EN
          OP_J:         next = JEX;
`endif
          default: begin
            next   = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR:  next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memready) next = MEMWB;
      MEMWR:   if (memready) next = FETCH;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end

  maindec_outdec u_outdec (
    .state    (state),
    .memready (memready),
    .ctrl     (ctrl)
  );

  // Hold every output low while reset is asserted.
  always_comb begin
    ctrl_g = reset_n ? ctrl : '0;
  end

  assign pcwrite  = ctrl_g.pcwrite;
  assign branch   = ctrl_g.branch;
  assign iord     = ctrl_g.iord;
  assign memwrite = ctrl_g.memwrite;
  assign irwrite  = ctrl_g.irwrite;
  assign regdst   = ctrl_g.regdst;
  assign memtoreg = ctrl_g.memtoreg;
  assign regwrite = ctrl_g.regwrite;
  assign alusrca  = ctrl_g.alusrca;
  assign alusrcb  = ctrl_g.alusrcb;
  assign pcsrc    = ctrl_g.pcsrc;
  assign aluop    = ctrl_g.aluop;
  assign illegal  = reset_n & bad_op;

endmodule

// File: tb/tb_maindec_fsm.sv
// Directed self-checking bench for maindec_fsm.
// Honours MAINDEC_JUMP_EN when choosing j-instruction expectations.
module tb_maindec_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       memready;
  logic       pcwrite, branch, iord, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maindec_fsm dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .memready (memready),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal)
  );

  // Word layout: pcw br iord mw irw rd m2r rw asa asb[2] pcs[2] aop[2] ill
  function automatic logic [15:0] w(
    input logic pcw, br, ior, mw, irw, rd, m2r, rw, asa,
    input logic [1:0] asb, pcs, aop,
    input logic ill
  );
    return {pcw, br, ior, mw, irw, rd, m2r, rw, asa, asb, pcs, aop, ill};
  endfunction

  localparam logic [15:0] ZERO = 16'h0;

  logic [15:0] obs;

  task automatic chk(input string tag, input logic [15:0] exp);
    #1;
    obs = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, aluop, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] f1, f0, dec, adr, mrd, mwb, mwr;
    logic [15:0] rex, rwb, bex, aex, awb, jex, ill;
    f1  = w(1,0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    f0  = w(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    dec = w(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    ill = w(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    adr = w(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    mrd = w(0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    mwb = w(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    mwr = w(0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    rex = w(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
    rwb = w(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    bex = w(0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    aex = adr;
    awb = w(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    jex = w(1,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);

    // Reset with memready high: everything low, across a clock edge too.
    reset_n  = 1'b0;
    memready = 1'b1;
    op       = 6'b000000;
    chk("rst_pre", ZERO);
    step();
    chk("rst_edge", ZERO);
    #2 reset_n = 1'b1;
    chk("fetch_after_rst", f1);

    // lw, no stalls: 5 cycles.
    op = 6'b100011;
    step(); chk("lw_dec", dec);
    step(); chk("lw_adr", adr);
    step(); chk("lw_rd", mrd);
    step(); chk("lw_wb", mwb);
    step(); chk("lw_fetch", f1);

    // FETCH stall, then sw with three low cycles in MEMWR.
    memready = 1'b0;
    op = 6'b101011;
    chk("fetch_stall", f0);
    step(); chk("fetch_stall2", f0);
    memready = 1'b1;
    chk("sw_fetch", f1);
    step(); chk("sw_dec", dec);
    step(); chk("sw_adr", adr);
    step(); memready = 1'b0; chk("sw_wr1", mwr);
    step(); chk("sw_wr2", mwr);
    step(); chk("sw_wr3", mwr);
    step(); memready = 1'b1; chk("sw_wr4", mwr);
    step(); chk("sw_fetch_end", f1);

    // R-type.
    op = 6'b000000;
    step(); chk("r_dec", dec);
    step(); chk("r_ex", rex);
    step(); chk("r_wb", rwb);
    step(); chk("r_fetch", f1);

    // beq.
    op = 6'b000100;
    step(); chk("beq_dec", dec);
    step(); chk("beq_ex", bex);
    step(); chk("beq_fetch", f1);

    // addi.
    op = 6'b001000;
    step(); chk("addi_dec", dec);
    step(); chk("addi_ex", aex);
    step(); chk("addi_wb", awb);
    step(); chk("addi_fetch", f1);

    // Unknown opcode: single illegal pulse, back to FETCH.
    op = 6'b111111;
    step(); chk("bad_dec", ill);
    step(); chk("bad_fetch", f1);

    // j: jump when enabled, illegal otherwise.
    op = 6'b000010;
`ifdef MAINDEC_JUMP_EN
    step(); chk("j_dec", dec);
    step(); chk("j_ex", jex);
    step(); chk("j_fetch", f1);
`else
    step(); chk("j_dec_ill", ill);
    step(); chk("j_fetch", f1);
    if (jex == ZERO) $display("unreachable");
`endif

    // Reset during a MEMWR stall aborts the store at once.
    op = 6'b101011;
    step(); chk("sw2_dec", dec);
    step(); chk("sw2_adr", adr);
    step(); memready = 1'b0; chk("sw2_wr", mwr);
    reset_n = 1'b0;
    chk("sw2_rst", ZERO);
    memready = 1'b1;
    chk("sw2_rst_mr", ZERO);
    step(); chk("sw2_rst_edge", ZERO);
    #2 reset_n = 1'b1;
    chk("resume_fetch", f1);
    op = 6'b100011;
    step(); chk("resume_dec", dec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
